// File: rtl/controller_ws_pkg.sv
// Shared types for the controller_ws instruction sequencer: FSM states,
// opcodes and the ALU-class opcode decode.
package controller_ws_pkg;

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8,
    FAULT      = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  // Opcodes that read an operand from memory and load the accumulator.
  function automatic logic is_aluop(input opcode_t op);
    return op inside {ADD, AND, XOR, LDA};
  endfunction

endpackage

// File: rtl/controller_ws_if.sv
// Controller-to-datapath bundle: opcode/status inputs to the controller,
// datapath strobes, fault flag and state observation back out.
interface controller_ws_if;
  import controller_ws_pkg::*;

  opcode_t opcode;
  logic    zero;
  logic    mem_ready;
  logic    run;
  logic    mem_rd;
  logic    load_ir;
  logic    halt;
  logic    inc_pc;
  logic    load_ac;
  logic    load_pc;
  logic    mem_wr;
  logic    bus_err;
  state_t  state;

  modport master (
    input  opcode, zero, mem_ready, run,
    output mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr,
    output bus_err, state
  );

  modport slave (
    output opcode, zero, mem_ready, run,
    input  mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr,
    input  bus_err, state
  );

endinterface

// File: rtl/controller_ws_wait_timer.sv
// Stall-cycle counter for memory phases; expired flags that the count has
// reached TIMEOUT and the counter stops there until cleared.
module wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/controller_ws.sv
// Eight-phase instruction sequencer with optional memory wait states,
// per-phase stall timeout into a sticky FAULT, and an optional HALTED park.
module controller_ws
  import controller_ws_pkg::*;
#(
  parameter bit          WAIT_EN   = 1'b1,
  parameter int unsigned TIMEOUT   = 15,
  parameter bit          HALT_STOP = 1'b1
) (
  input logic            clk,
  input logic            reset,
  controller_ws_if.master bus
);

  state_t state_q;
  logic   bus_err_q;
  logic   aluop;
  logic   stall_phase;
  logic   stalled;
  logic   timer_clear;
  logic   expired;

  logic mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;

  assign aluop = is_aluop(bus.opcode);

  always_comb begin
    stall_phase = 1'b0;
    case (state_q)
      INST_FETCH: stall_phase = 1'b1;
      OP_FETCH:   stall_phase = aluop;
      STORE:      stall_phase = (bus.opcode == STO);
      default:    stall_phase = 1'b0;
    endcase
  end

  // A cycle is a stall only when waits are enabled and memory is not ready;
  // any other cycle leaves the state, so clearing the timer there keeps the
  // count per-phase.
  assign stalled     = WAIT_EN && stall_phase && !bus.mem_ready;
  assign timer_clear = !stalled;

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (stalled),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= INST_ADDR;
      bus_err_q <= 1'b0;
    end else if (stalled) begin
      if (expired) begin
        state_q   <= FAULT;
        bus_err_q <= 1'b1;
      end
    end else begin
      case (state_q)
        INST_ADDR:  state_q <= INST_FETCH;
        INST_FETCH: state_q <= INST_LOAD;
        INST_LOAD:  state_q <= IDLE;
        IDLE:       state_q <= OP_ADDR;
        OP_ADDR:    state_q <= (HALT_STOP && bus.opcode == HLT) ? HALTED : OP_FETCH;
        OP_FETCH:   state_q <= ALU_OP;
        ALU_OP:     state_q <= STORE;
        STORE:      state_q <= INST_ADDR;
        HALTED:     state_q <= bus.run ? INST_ADDR : HALTED;
        FAULT:      state_q <= FAULT;
        default:    state_q <= INST_ADDR;
      endcase
    end
  end

  // Controls decode from state plus the live opcode, so reset forcing
  // INST_ADDR silences every strobe without waiting for a clock.
  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    case (state_q)
      INST_FETCH: mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = (bus.opcode == HLT);
      end
      OP_FETCH: mem_rd = aluop;
      ALU_OP: begin
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = (bus.opcode == SKZ) && bus.zero;
        load_pc = (bus.opcode == JMP);
      end
      STORE: begin
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = (bus.opcode == JMP);
        load_pc = (bus.opcode == JMP);
        mem_wr  = (bus.opcode == STO);
      end
      HALTED:  halt = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_rd  = mem_rd;
  assign bus.load_ir = load_ir;
  assign bus.halt    = halt;
  assign bus.inc_pc  = inc_pc;
  assign bus.load_ac = load_ac;
  assign bus.load_pc = load_pc;
  assign bus.mem_wr  = mem_wr;
  assign bus.bus_err = bus_err_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_controller_ws.sv
// Directed bench for controller_ws: a wait-state/halt instance (TIMEOUT=4)
// and a legacy instance (no waits, no halt park) checked cycle by cycle.
module tb_controller_ws;
  import controller_ws_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_m;
  logic rst_l;

  controller_ws_if m_bus ();
  controller_ws_if l_bus ();

  controller_ws #(.WAIT_EN(1'b1), .TIMEOUT(4), .HALT_STOP(1'b1)) dut_main (
    .clk   (clk),
    .reset (rst_m),
    .bus   (m_bus)
  );

  controller_ws #(.WAIT_EN(1'b0), .TIMEOUT(15), .HALT_STOP(1'b0)) dut_legacy (
    .clk   (clk),
    .reset (rst_l),
    .bus   (l_bus)
  );

  // Control vector order: {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}
  logic [6:0] m_ctl;
  logic [6:0] l_ctl;
  assign m_ctl = {m_bus.mem_rd, m_bus.load_ir, m_bus.halt, m_bus.inc_pc,
                  m_bus.load_ac, m_bus.load_pc, m_bus.mem_wr};
  assign l_ctl = {l_bus.mem_rd, l_bus.load_ir, l_bus.halt, l_bus.inc_pc,
                  l_bus.load_ac, l_bus.load_pc, l_bus.mem_wr};

  int tests_run    = 0;
  int tests_failed = 0;

  state_t exp_st [14];
  logic   rdy_v  [14];
  logic   rd_v   [14];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input opcode_t op, input logic z,
                               input logic rdy, input logic rn);
    m_bus.opcode    = op;
    m_bus.zero      = z;
    m_bus.mem_ready = rdy;
    m_bus.run       = rn;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] legacyCtl(input int p, input opcode_t op, input logic z);
    logic alu;
    logic [6:0] v;
    alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    v = 7'b0;
    case (p)
      1: v = 7'b1000000;
      2: v = 7'b1100000;
      3: v = 7'b1100000;
      4: v = {2'b00, op == HLT, 4'b1000};
      5: v = {alu, 6'b0};
      6: v = {alu, 2'b00, (op == SKZ) && z, alu, op == JMP, 1'b0};
      7: v = {alu, 2'b00, op == JMP, alu, op == JMP, op == STO};
      default: v = 7'b0;
    endcase
    return v;
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_st = '{INST_ADDR, INST_FETCH, INST_FETCH, INST_FETCH, INST_FETCH,
               INST_LOAD, IDLE, OP_ADDR, OP_FETCH, OP_FETCH, OP_FETCH,
               OP_FETCH, ALU_OP, STORE};
    rdy_v  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b1, 1'b0, 1'b0};
    rd_v   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
               1'b1, 1'b1, 1'b1, 1'b1};

    rst_m = 1'b0;
    rst_l = 1'b0;
    l_bus.opcode    = ADD;
    l_bus.zero      = 1'b0;
    l_bus.mem_ready = 1'b0;
    l_bus.run       = 1'b0;
    applyStimulus(STO, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("reset_state", m_bus.state, INST_ADDR);
    checkOutput("reset_ctl", m_ctl, 7'b0);
    checkOutput("reset_bus_err", m_bus.bus_err, 1'b0);
    tick();
    checkOutput("reset_hold_state", m_bus.state, INST_ADDR);
    rst_m = 1'b1;

    // ADD with three stalled cycles in both INST_FETCH and OP_FETCH.
    for (int c = 0; c < 14; c++) begin
      applyStimulus(ADD, 1'b0, rdy_v[c], 1'b0);
      checkOutput($sformatf("add_stall_state_c%0d", c), m_bus.state, exp_st[c]);
      checkOutput($sformatf("add_stall_mem_rd_c%0d", c), m_bus.mem_rd, rd_v[c]);
      if (c == 12) checkOutput("add_alu_load_ac", m_bus.load_ac, 1'b1);
      tick();
    end
    checkOutput("add_14_cycles_back_to_inst_addr", m_bus.state, INST_ADDR);

    // SKZ with zero set and clear, then JMP.
    applyStimulus(SKZ, 1'b1, 1'b1, 1'b0);
    repeat (6) tick();
    checkOutput("skz_z1_state", m_bus.state, ALU_OP);
    checkOutput("skz_z1_ctl", m_ctl, 7'b0001000);
    repeat (2) tick();
    applyStimulus(SKZ, 1'b0, 1'b1, 1'b0);
    repeat (6) tick();
    checkOutput("skz_z0_ctl", m_ctl, 7'b0000000);
    repeat (2) tick();
    applyStimulus(JMP, 1'b0, 1'b1, 1'b0);
    repeat (6) tick();
    checkOutput("jmp_alu_ctl", m_ctl, 7'b0000010);
    tick();
    checkOutput("jmp_store_state", m_bus.state, STORE);
    checkOutput("jmp_store_ctl", m_ctl, 7'b0001010);
    tick();
    checkOutput("jmp_done_state", m_bus.state, INST_ADDR);

    // Timeout: five stalled cycles in INST_FETCH trip FAULT.
    applyStimulus(ADD, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("to_enter_fetch", m_bus.state, INST_FETCH);
    repeat (4) tick();
    checkOutput("to_fifth_cycle_still_fetch", m_bus.state, INST_FETCH);
    checkOutput("to_fetch_mem_rd_steady", m_bus.mem_rd, 1'b1);
    tick();
    checkOutput("to_fault_state", m_bus.state, FAULT);
    checkOutput("to_fault_bus_err", m_bus.bus_err, 1'b1);
    checkOutput("to_fault_ctl", m_ctl, 7'b0);
    applyStimulus(ADD, 1'b0, 1'b1, 1'b1);
    repeat (3) tick();
    checkOutput("to_fault_sticky_state", m_bus.state, FAULT);
    checkOutput("to_fault_sticky_bus_err", m_bus.bus_err, 1'b1);
    rst_m = 1'b0;
    #1;
    checkOutput("to_reset_clears_state", m_bus.state, INST_ADDR);
    checkOutput("to_reset_clears_bus_err", m_bus.bus_err, 1'b0);
    tick();
    rst_m = 1'b1;

    // Ready on the cycle the count reaches TIMEOUT wins over the fault.
    applyStimulus(ADD, 1'b0, 1'b0, 1'b0);
    tick();
    repeat (4) tick();
    applyStimulus(ADD, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("to_edge_ready_advances", m_bus.state, INST_LOAD);
    checkOutput("to_edge_no_bus_err", m_bus.bus_err, 1'b0);
    repeat (6) tick();
    checkOutput("to_edge_done_state", m_bus.state, INST_ADDR);

    // HLT parks in HALTED until run.
    applyStimulus(HLT, 1'b0, 1'b1, 1'b0);
    repeat (4) tick();
    checkOutput("hlt_op_addr_ctl", m_ctl, 7'b0011000);
    tick();
    for (int c = 0; c < 20; c++) begin
      checkOutput($sformatf("hlt_parked_state_c%0d", c), m_bus.state, HALTED);
      checkOutput($sformatf("hlt_parked_ctl_c%0d", c), m_ctl, 7'b0010000);
      tick();
    end
    applyStimulus(HLT, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("hlt_run_restart", m_bus.state, INST_ADDR);

    // STO stalled in STORE, then asynchronous reset between edges.
    applyStimulus(STO, 1'b0, 1'b1, 1'b0);
    repeat (6) tick();
    applyStimulus(STO, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("sto_store_state", m_bus.state, STORE);
    checkOutput("sto_store_ctl", m_ctl, 7'b0000001);
    tick();
    checkOutput("sto_store_stalled", m_bus.state, STORE);
    #2;
    rst_m = 1'b0;
    #1;
    checkOutput("sto_async_reset_state", m_bus.state, INST_ADDR);
    checkOutput("sto_async_reset_mem_wr", m_bus.mem_wr, 1'b0);
    tick();
    checkOutput("sto_reset_held_state", m_bus.state, INST_ADDR);

    // Legacy instance: 64 instructions, 512 cycles, mem_ready/run ignored.
    rst_l = 1'b1;
    for (int v = 0; v < 64; v++) begin
      for (int p = 0; p < 8; p++) begin
        l_bus.opcode    = opcode_t'(v % 8);
        l_bus.zero      = ((v / 8) % 2) == 1;
        l_bus.mem_ready = 1'($urandom_range(0, 1));
        l_bus.run       = 1'($urandom_range(0, 1));
        #1;
        checkOutput($sformatf("legacy_v%0d_p%0d", v, p), {l_bus.state, l_ctl},
                    {4'(p), legacyCtl(p, opcode_t'(v % 8), ((v / 8) % 2) == 1)});
        tick();
      end
    end
    checkOutput("legacy_no_bus_err", l_bus.bus_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/controller_ws.md
CONTROLLER_WS -- requirements
Module: controller_ws

Interface
REQ-001 Parameter WAIT_EN, default 1: 1 = memory phases stall on mem_ready; 0 = legacy fixed one-cycle phases, mem_ready ignored.
REQ-002 Parameter TIMEOUT, default 15, range 1..255: maximum stall cycles per memory phase before fault.
REQ-003 Parameter HALT_STOP, default 1: 1 = HLT parks FSM in HALTED; 0 = legacy, FSM keeps cycling with halt pulsed.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 opcode  input  opcode_t (3)  current instruction opcode: HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP.
REQ-007 zero  input  1  accumulator-zero flag.
REQ-008 mem_ready  input  1  memory access complete this cycle.
REQ-009 run  input  1  restart request, sampled in HALTED only.
REQ-010 mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr  output  1 each  datapath controls.
REQ-011 bus_err  output  1  sticky memory-timeout flag.
REQ-012 state  output  state_t  current FSM state, for observation.

Function
REQ-013 Nominal sequence SHALL be INST_ADDR > INST_FETCH > INST_LOAD > IDLE > OP_ADDR > OP_FETCH > ALU_OP > STORE > INST_ADDR.
REQ-014 ALUOP = opcode in {ADD, AND, XOR, LDA}; outputs are Moore-plus-opcode combinational decode of state.
REQ-015 INST_ADDR: all controls 0. INST_FETCH: mem_rd. INST_LOAD, IDLE: mem_rd, load_ir.
REQ-016 OP_ADDR: inc_pc=1; halt=(opcode==HLT). OP_FETCH: mem_rd=ALUOP.
REQ-017 ALU_OP: mem_rd=load_ac=ALUOP; inc_pc=(SKZ and zero); load_pc=JMP.
REQ-018 STORE: mem_rd=load_ac=ALUOP; inc_pc=load_pc=JMP; mem_wr=STO.
REQ-019 Stall phases: INST_FETCH always, OP_FETCH when ALUOP, STORE when STO; with WAIT_EN=1 the FSM holds there, controls unchanged, until mem_ready=1.
REQ-020 mem_ready=1 on the first cycle of a stall phase gives zero added latency; each low cycle adds exactly one cycle.
REQ-021 Wait counter clears on entering any state; increments each stalled cycle; counter==TIMEOUT with mem_ready=0 moves FSM to FAULT next edge.
REQ-022 mem_ready=1 on the cycle counter reaches TIMEOUT wins: normal advance, no fault.
REQ-023 FAULT: all controls 0, bus_err=1; exit only by reset.
REQ-024 HALT_STOP=1: OP_ADDR with HLT goes to HALTED; HALTED holds halt=1, other controls 0.
REQ-025 HALTED with run=1 goes to INST_ADDR next edge; run ignored in every other state.
REQ-026 HALT_STOP=0 and WAIT_EN=0: cycle-exact with the legacy 8-state controller.
REQ-027 Full instruction latency without stalls: 8 cycles.

Reset
REQ-028 reset=0 forces state=INST_ADDR, wait counter=0, bus_err=0 immediately, independent of clk, including mid-stall and in FAULT/HALTED.
REQ-029 While reset=0 all controls SHALL be 0; first transition on first rising edge after reset release.

Structure
REQ-030 state_t (4-bit, adding HALTED, FAULT) and opcode_t live in package typedefs; ALUOP decode as a package function.
REQ-031 Wait/timeout counter is sub-module wait_timer (width $clog2(TIMEOUT+1), inputs clear/enable, output expired).
REQ-032 Target 150-300 lines RTL including wait_timer.

Verification
REQ-033 WAIT_EN=0, HALT_STOP=0, legacy 64-vector stimulus/response pattern set -> zero mismatches over 512 cycles.
REQ-034 ADD, mem_ready low 3 cycles in INST_FETCH and OP_FETCH -> instruction takes 14 cycles; mem_rd steady through stalls.
REQ-035 TIMEOUT=4, mem_ready held 0 in INST_FETCH -> FAULT after 5th cycle, bus_err=1 until reset; mem_ready=1 on 4th count -> no fault.
REQ-036 HLT, HALT_STOP=1 -> HALTED, halt=1 held 20 cycles; run pulse -> INST_ADDR next edge.
REQ-037 SKZ with zero=1 -> inc_pc=1 in ALU_OP; zero=0 -> inc_pc=0; JMP -> load_pc=1 in ALU_OP and STORE.
REQ-038 reset=0 asserted mid-edge during STORE stall -> state=INST_ADDR, mem_wr=0 before next clk edge.
